// File: rtl/slice_byte_serializer.sv
// slice_byte_serializer: streams the bytes of a wide word one per cycle, byte 0 first, optionally skipping zero bytes.
module slice_byte_serializer #(
    parameter int NBYTES    = 8,
    parameter int W         = 8,
    parameter bit DROP_ZERO = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [NBYTES*W-1:0] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [W-1:0]        out_data,
    output logic                out_last,
    output logic [15:0]         word_cnt
);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t state;
    logic [NBYTES-1:0] mask, keep, clr;
    logic [NBYTES*W-1:0] data;
    logic [W-1:0] sel;
    logic one_left, in_hs, out_hs;
    // lowest-index kept byte wins; clr marks it for removal on handshake
    always_comb begin
        sel = '0;
        clr = '0;
        for (int i = NBYTES - 1; i >= 0; i--)
            if (mask[i]) begin
                sel = data[(NBYTES-i)*W-1 -: W];
                clr = '0;
                clr[i] = 1'b1;
            end
    end
    always_comb begin
        keep = '0;
        for (int i = 0; i < NBYTES; i++)
            keep[i] = !DROP_ZERO || (|in_data[(NBYTES-i)*W-1 -: W]);
    end
    assign one_left  = (mask != '0) && ((mask & (mask - NBYTES'(1))) == '0);
    assign out_valid = state == SHIFT;
    assign out_last  = out_valid && one_left;
    assign out_data  = out_valid ? sel : '0;
    assign in_ready  = !rst && (state == IDLE || (out_last && out_ready));
    assign in_hs     = in_valid && in_ready;
    assign out_hs    = out_valid && out_ready;
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            mask     <= '0;
            data     <= '0;
            word_cnt <= '0;
        end else begin
            if (in_hs) begin
                data  <= in_data;
                mask  <= keep;
                state <= keep != '0 ? SHIFT : IDLE;
            end else if (out_hs) begin
                mask  <= mask & ~clr;
                state <= out_last ? IDLE : SHIFT;
            end
            word_cnt <= word_cnt + 16'(out_hs && out_last) + 16'(in_hs && keep == '0);
        end
    end
endmodule

// File: tb/tb_slice_byte_serializer.sv
// tb_slice_byte_serializer: directed per-cycle vectors against a DROP_ZERO=0 and a DROP_ZERO=1 instance.
module tb_slice_byte_serializer;
    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
    logic [63:0] in_data = '0;
    logic ir0, ov0, ol0, ir1, ov1, ol1;
    logic [7:0] od0, od1;
    logic [15:0] wc0, wc1;
    int n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    slice_byte_serializer #(.NBYTES(8), .W(8), .DROP_ZERO(1'b0)) u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0), .in_data(in_data),
        .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .out_last(ol0), .word_cnt(wc0));
    slice_byte_serializer #(.NBYTES(8), .W(8), .DROP_ZERO(1'b1)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
        .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_last(ol1), .word_cnt(wc1));

    typedef struct {
        bit s, r, iv;
        logic [63:0] d;
        bit ordy, chk, eov;
        logic [7:0] eod;
        bit eol, eir;
        logic [15:0] ecnt;
    } vec_t;
    vec_t q[$];

    task automatic add(input bit s, r, iv, input logic [63:0] d, input bit ordy, chk, eov,
                       input logic [7:0] eod, input bit eol, eir, input logic [15:0] ecnt);
        vec_t v;
        v.s = s; v.r = r; v.iv = iv; v.d = d; v.ordy = ordy; v.chk = chk; v.eov = eov;
        v.eod = eod; v.eol = eol; v.eir = eir; v.ecnt = ecnt;
        q.push_back(v);
    endtask

    task automatic add_rst(input bit s);
        add(s, 1, 0, 64'h0, 1, 0, 0, 8'h00, 0, 0, 16'd0);
        add(s, 1, 0, 64'h0, 1, 0, 0, 8'h00, 0, 0, 16'd0);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic drive(input bit r, iv, input logic [63:0] d, input bit ordy);
        @(negedge clk);
        rst = r; in_valid = iv; in_data = d; out_ready = ordy;
        #1;
    endtask

    task automatic chk_all(input bit s, input string tag, input bit eov, input logic [7:0] eod,
                           input bit eol, eir, input logic [15:0] ecnt);
        chk({tag, ".out_valid"}, s ? ov1 : ov0, eov);
        chk({tag, ".out_data"}, s ? od1 : od0, eod);
        chk({tag, ".out_last"}, s ? ol1 : ol0, eol);
        chk({tag, ".in_ready"}, s ? ir1 : ir0, eir);
        chk({tag, ".word_cnt"}, s ? wc1 : wc0, ecnt);
    endtask

    localparam logic [63:0] WA = 64'hA53C0000A53C0000;
    localparam logic [63:0] WB = 64'h0102030405060708;
    localparam logic [63:0] W1 = 64'h1111111111111111;
    localparam logic [63:0] W2 = 64'h2222222222222222;
    logic [7:0] wa_bytes [8] = '{8'hA5, 8'h3C, 8'h00, 8'h00, 8'hA5, 8'h3C, 8'h00, 8'h00};

    initial begin
        // all bytes kept when DROP_ZERO=0
        add_rst(0);
        add(0, 0, 1, WA, 1, 1, 0, 8'h00, 0, 1, 16'd0);
        for (int c = 0; c < 8; c++)
            add(0, 0, 0, 64'h0, 1, 1, 1, wa_bytes[c], c == 7, c == 7, 16'd0);
        add(0, 0, 0, 64'h0, 1, 1, 0, 8'h00, 0, 1, 16'd1);
        // zero bytes dropped
        add_rst(1);
        add(1, 0, 1, WA, 1, 1, 0, 8'h00, 0, 1, 16'd0);
        add(1, 0, 0, 64'h0, 1, 1, 1, 8'hA5, 0, 0, 16'd0);
        add(1, 0, 0, 64'h0, 1, 1, 1, 8'h3C, 0, 0, 16'd0);
        add(1, 0, 0, 64'h0, 1, 1, 1, 8'hA5, 0, 0, 16'd0);
        add(1, 0, 0, 64'h0, 1, 1, 1, 8'h3C, 1, 1, 16'd0);
        add(1, 0, 0, 64'h0, 1, 1, 0, 8'h00, 0, 1, 16'd1);
        // all-zero words counted, never emitted
        add_rst(1);
        for (int c = 0; c < 3; c++)
            add(1, 0, 1, 64'h0, 1, 1, 0, 8'h00, 0, 1, 16'(c));
        add(1, 0, 0, 64'h0, 1, 1, 0, 8'h00, 0, 1, 16'd3);
        // out_ready 1,0,0,1,...: byte n held for cycles k=3n-5..3n-3
        add_rst(0);
        add(0, 0, 1, WB, 1, 1, 0, 8'h00, 0, 1, 16'd0);
        for (int k = 0; k < 22; k++)
            add(0, 0, 0, 64'h0, k % 3 == 0, 1, 1, 8'((k + 5) / 3), (k + 5) / 3 == 8,
                (k + 5) / 3 == 8 && k % 3 == 0, 16'd0);
        add(0, 0, 0, 64'h0, 1, 1, 0, 8'h00, 0, 1, 16'd1);
        // back-to-back words with no bubble
        add_rst(0);
        add(0, 0, 1, W1, 1, 1, 0, 8'h00, 0, 1, 16'd0);
        for (int c = 1; c <= 8; c++)
            add(0, 0, 1, W2, 1, 1, 1, 8'h11, c == 8, c == 8, 16'd0);
        for (int c = 9; c <= 16; c++)
            add(0, 0, 0, 64'h0, 1, 1, 1, 8'h22, c == 16, c == 16, 16'd1);
        add(0, 0, 0, 64'h0, 1, 1, 0, 8'h00, 0, 1, 16'd2);
        // last byte coincides with an all-zero word: +2
        add_rst(1);
        add(1, 0, 1, 64'h00000000000000AB, 1, 1, 0, 8'h00, 0, 1, 16'd0);
        add(1, 0, 1, 64'h0, 1, 1, 1, 8'hAB, 1, 1, 16'd0);
        add(1, 0, 0, 64'h0, 1, 1, 0, 8'h00, 0, 1, 16'd2);

        foreach (q[n]) begin
            drive(q[n].r, q[n].iv, q[n].d, q[n].ordy);
            if (q[n].chk)
                chk_all(q[n].s, $sformatf("vec%0d", n), q[n].eov, q[n].eod, q[n].eol, q[n].eir, q[n].ecnt);
        end

        // reset in the middle of a word
        drive(1, 0, 64'h0, 1);
        drive(1, 0, 64'h0, 1);
        drive(0, 1, WB, 1);
        for (int c = 1; c <= 8; c++) drive(0, 0, 64'h0, 1);
        drive(0, 1, WB, 1);
        chk_all(0, "pre", 0, 8'h00, 0, 1, 16'd1);
        for (int c = 1; c <= 3; c++) begin
            drive(0, 0, 64'h0, 1);
            chk({"mid.out_data"}, od0, 64'(c));
        end
        drive(1, 1, WB, 1);
        chk("rst.in_ready", ir0, 0);
        drive(0, 0, 64'h0, 1);
        chk_all(0, "post", 0, 8'h00, 0, 1, 16'd0);
        drive(0, 1, WB, 1);
        for (int c = 1; c <= 8; c++) begin
            drive(0, 0, 64'h0, 1);
            chk_all(0, $sformatf("again%0d", c), 1, 8'(c), c == 8, c == 8, 16'd0);
        end
        drive(0, 0, 64'h0, 1);
        chk("again.word_cnt", wc0, 16'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/slice_byte_serializer.md
SLICE_BYTE_SERIALIZER -- requirements
Module: slice_byte_serializer

Interface
REQ-001 SHALL have parameter NBYTES, default 8: bytes per input word (one 2x4 byte array).
REQ-002 SHALL have parameter W, default 8: bits per byte.
REQ-003 SHALL have parameter DROP_ZERO, default 0: when 1, bytes equal to 0 are suppressed.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port in_valid  input  1  in_data holds a word.
REQ-007 SHALL have port in_ready  output  1  block accepts a word this cycle.
REQ-008 SHALL have port in_data  input  NBYTES*W  packed byte array; byte 0 = bits [NBYTES*W-1 -: W].
REQ-009 SHALL have port out_valid  output  1  out_data holds a byte.
REQ-010 SHALL have port out_ready  input  1  downstream accepts the byte.
REQ-011 SHALL have port out_data  output  W  current byte.
REQ-012 SHALL have port out_last  output  1  current byte is the last byte emitted for its word.
REQ-013 SHALL have port word_cnt  output  16  count of completed words; wraps modulo 2^16.

Function
REQ-014 An input handshake SHALL occur when in_valid && in_ready.
REQ-015 An output handshake SHALL occur when out_valid && out_ready.
REQ-016 On an input handshake, the block SHALL register in_data together with a keep mask of NBYTES bits.
REQ-017 Keep mask: all ones when DROP_ZERO=0; when DROP_ZERO=1, bit i set iff byte i is non-zero.
REQ-018 The block SHALL have exactly two states: IDLE and SHIFT.
REQ-019 IDLE -> SHIFT SHALL occur on an input handshake with a non-zero keep mask.
REQ-020 An input handshake with an all-zero keep mask SHALL remain in IDLE, emit no byte, and increment word_cnt the following cycle.
REQ-021 In SHIFT, out_valid SHALL be 1 and out_data SHALL be the lowest-index byte whose mask bit is set (byte 0 first).
REQ-022 out_last SHALL be 1 iff exactly one mask bit remains set; it SHALL be 0 whenever out_valid is 0.
REQ-023 On an output handshake that is not last, the block SHALL clear the emitted byte's mask bit.
REQ-024 On a last-byte output handshake, the block SHALL increment word_cnt and leave SHIFT.
REQ-025 in_ready SHALL be 1 in IDLE, and in SHIFT only during the last-byte output handshake; it SHALL NOT combinationally depend on in_valid.
REQ-026 Last-byte handshake with a simultaneous input handshake (non-zero mask): the block SHALL load the new word and stay in SHIFT, giving zero bubble cycles.
REQ-027 Last-byte handshake with a simultaneous all-zero input: the block SHALL go to IDLE and increment word_cnt by 2 in total.
REQ-028 With out_ready=0, out_data, out_last and the mask SHALL hold stable; out_valid SHALL NOT drop before its handshake.
REQ-029 Latency SHALL be 1 cycle from input handshake to first out_valid.
REQ-030 Sustained throughput SHALL be one byte per cycle.
REQ-031 out_data SHALL be 0 when out_valid is 0.

Reset
REQ-032 When rst=1 at a clock edge, the block SHALL go to IDLE, clear the mask and data registers, and set word_cnt=0.
REQ-033 After reset: out_valid=0, out_last=0, out_data=0, word_cnt=0, in_ready=1 in the first cycle after rst deasserts.
REQ-034 Reset during SHIFT SHALL discard the remaining bytes without an out_last pulse and SHALL NOT increment word_cnt.
REQ-035 While rst=1, in_ready SHALL be 0 and no input handshake SHALL be counted.

Verification
REQ-036 DROP_ZERO=0, in_data=0xA53C0000A53C0000, out_ready=1: A5,3C,00,00,A5,3C,00,00 on 8 consecutive cycles; out_last on the 8th; word_cnt=1.
REQ-037 DROP_ZERO=1, same word: A5,3C,A5,3C; out_last on the 4th; word_cnt=1.
REQ-038 DROP_ZERO=1, in_data=0 for 3 words: no out_valid; in_ready stays 1; word_cnt=3.
REQ-039 out_ready toggled 1,0,0,1,... on 0x0102030405060708: bytes 01..08 in order, each stable while stalled, none lost or duplicated.
REQ-040 Back-to-back words 0x1111111111111111 and 0x2222222222222222, in_valid held high: 16 consecutive out_valid cycles, out_last at cycles 8 and 16, in_ready high on cycle 8.
REQ-041 rst asserted after the 3rd byte of a word: next cycle out_valid=0, word_cnt=0; the following word streams normally from byte 0.
